// File: rtl/seq_div_n_bits_pkg.sv
// Shared types and helpers for the sequential restoring divider.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package seq_div_n_bits_pkg;

    // Controller states: waiting, iterating one bit per clock, result pulse
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of a counter that must hold the values 0..n inclusive
    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/seq_div_n_bits_div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract, restore on borrow.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module seq_div_n_bits_div_step #(
    parameter int N = 8
) (
    input  logic [N-1:0] rem_in,
    input  logic         dvd_bit,
    input  logic [N-1:0] divisor,
    output logic [N-1:0] rem_out,
    output logic         q_bit
);

    logic [N:0]   shifted;
    logic [N+1:0] trial;

    // Trial subtract on N+1 bits; the extra top bit is the borrow (negative result)
    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = {1'b0, shifted} - {2'b00, divisor};
        q_bit   = ~trial[N+1];
        // Since rem_in < divisor, both the kept difference and the restored
        // value fit in N bits.
        rem_out = q_bit ? N'(trial) : N'(shifted);
    end

endmodule

// File: rtl/seq_div_n_bits.sv
// Unsigned N-bit sequential restoring divider, one quotient bit per clock, MSB first.
// Latency: N cycles from accepted start to done; divide-by-zero answers on the next cycle.
// Backpressure: start is only accepted while not busy; a start during CALC is dropped.
module seq_div_n_bits
    import seq_div_n_bits_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         aclr,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero
);

    localparam int CW = cnt_width(N);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] step_cnt;
    logic [N-1:0]  dvd_r;     // dividend, shifted left so the MSB feeds the next step
    logic [N-1:0]  dvs_r;     // captured divisor
    logic [N-1:0]  rem_r;     // partial remainder
    logic [N-1:0]  quo_r;     // quotient bits collected so far
    logic [N-1:0]  rem_nxt;
    logic          q_bit;
    logic          accept;
    logic          last_step;
    logic          dvs_zero;

    seq_div_n_bits_div_step #(
        .N(N)
    ) div_step (
        .rem_in  (rem_r),
        .dvd_bit (dvd_r[N-1]),
        .divisor (dvs_r),
        .rem_out (rem_nxt),
        .q_bit   (q_bit)
    );

    // Next-state decode: start is honoured only outside CALC
    always_comb begin
        state_nxt = state;
        accept    = start && (state != CALC);
        last_step = (step_cnt == CW'(1));
        dvs_zero  = (divisor == '0);
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_nxt = dvs_zero ? DONE : CALC;
                end else begin
                    state_nxt = IDLE;
                end
            end
            CALC: begin
                if (last_step) begin
                    state_nxt = DONE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Iteration datapath: capture operands on accept, advance one bit per CALC cycle
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            step_cnt <= '0;
            dvd_r    <= '0;
            dvs_r    <= '0;
            rem_r    <= '0;
            quo_r    <= '0;
        end else if (accept) begin
            step_cnt <= CW'(N);
            dvd_r    <= dividend;
            dvs_r    <= divisor;
            rem_r    <= '0;
            quo_r    <= '0;
        end else if (state == CALC) begin
            step_cnt <= step_cnt - CW'(1);
            dvd_r    <= dvd_r << 1;
            rem_r    <= rem_nxt;
            quo_r    <= {quo_r[N-2:0], q_bit};
        end
    end

    // Visible results: status flags follow the next state, data only moves on completion
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            busy <= (state_nxt == CALC);
            done <= (state_nxt == DONE);
            if (accept) begin
                div_by_zero <= dvs_zero;
                // A zero divisor skips CALC entirely and answers immediately
                if (dvs_zero) begin
                    quotient  <= '1;
                    remainder <= dividend;
                end
            end else if ((state == CALC) && last_step) begin
                quotient  <= {quo_r[N-2:0], q_bit};
                remainder <= rem_nxt;
            end
        end
    end

endmodule

// File: tb/tb_seq_div_n_bits.sv
`timescale 1ns/1ps
module tb_seq_div_n_bits;
    import seq_div_n_bits_pkg::*;

    localparam int N     = 8;
    localparam int TOTAL = 1000;

    logic         clk = 1'b0;
    logic         aclr;
    logic         start;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;

    int n_chk = 0;
    int n_err = 0;

    // Expected results for the back-to-back stream, oldest first
    logic [N-1:0] eq_q[$];
    logic [N-1:0] er_q[$];
    logic         ez_q[$];
    int           gap_q[$];

    always #5 clk = ~clk;

    seq_div_n_bits #(
        .N(N)
    ) dut (
        .clk         (clk),
        .aclr        (aclr),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: plain integer division, with the defined divide-by-zero answer
    function automatic void ref_div(input logic [N-1:0] a, input logic [N-1:0] b,
                                    output logic [N-1:0] q, output logic [N-1:0] r,
                                    output logic z);
        if (b == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            q = a / b;
            r = a % b;
            z = 1'b0;
        end
    endfunction

    // One isolated operation: start for one cycle, wait for done, check everything
    task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         ez;
        int           cyc;
        int           busy_cyc;
        ref_div(a, b, eq, er, ez);
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start    = 1'b0;
        cyc      = 0;
        busy_cyc = 0;
        while (!done && cyc < 4 * N) begin
            if (busy) busy_cyc++;
            @(negedge clk);
            cyc++;
        end
        chk({tag, " done"}, done, 1);
        chk({tag, " latency"}, cyc, (b == 0) ? 0 : N);
        chk({tag, " busy_cycles"}, busy_cyc, (b == 0) ? 0 : N);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " quotient"}, quotient, eq);
        chk({tag, " remainder"}, remainder, er);
        chk({tag, " div_by_zero"}, div_by_zero, ez);
        if (b != 0) begin
            chk({tag, " identity"}, 32'(quotient) * 32'(b) + 32'(remainder), 32'(a));
            chk({tag, " rem_lt_div"}, 32'(remainder < b), 1);
        end
        @(negedge clk);
        chk({tag, " done_pulse_width"}, done, 0);
    endtask

    // Drive the idx-th back-to-back operation and queue its expected result
    task automatic issue_op(input int idx);
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] eq;
        logic [N-1:0] er;
        logic         ez;
        if (idx == 0) begin
            a = 8'd100;
            b = 8'd7;
        end else if (idx == 1) begin
            a = 8'd200;
            b = 8'd3;
        end else begin
            a = N'($urandom_range(0, (1 << N) - 1));
            b = ($urandom_range(0, 15) == 0) ? '0 : N'($urandom_range(1, (1 << N) - 1));
        end
        ref_div(a, b, eq, er, ez);
        eq_q.push_back(eq);
        er_q.push_back(er);
        ez_q.push_back(ez);
        gap_q.push_back((b == 0) ? 1 : N + 1);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
    endtask

    initial begin
        int           n_done;
        int           n_busy;
        logic [N-1:0] q_seen;
        logic [N-1:0] r_seen;
        int           issued;
        int           got;
        int           cyc;
        int           last_done;

        aclr     = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst quotient", quotient, 0);
        chk("rst remainder", remainder, 0);
        chk("rst div_by_zero", div_by_zero, 0);
        chk("rst state", 32'(dut.state), 32'(IDLE));
        @(negedge clk);
        aclr = 1'b0;

        run_op("100/7", 8'd100, 8'd7);
        run_op("5/0", 8'd5, 8'd0);
        run_op("3/10", 8'd3, 8'd10);
        run_op("255/1", 8'd255, 8'd1);

        // A second start arriving mid-operation must be dropped
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd100;
        divisor  = 8'd7;
        @(negedge clk);
        start    = 1'b0;
        repeat (3) @(negedge clk);
        start    = 1'b1;
        dividend = 8'd200;
        divisor  = 8'd3;
        @(negedge clk);
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        n_done   = 0;
        q_seen   = '0;
        r_seen   = '0;
        for (int i = 0; i < 20; i++) begin
            if (done) begin
                n_done++;
                q_seen = quotient;
                r_seen = remainder;
            end
            @(negedge clk);
        end
        chk("ignored_start done_count", n_done, 1);
        chk("ignored_start quotient", q_seen, 14);
        chk("ignored_start remainder", r_seen, 2);

        // Asynchronous clear in the middle of CALC, away from any clock edge
        @(negedge clk);
        start    = 1'b1;
        dividend = 8'd50;
        divisor  = 8'd3;
        @(negedge clk);
        start    = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_aclr busy", busy, 1);
        #2;
        aclr = 1'b1;
        #1;
        chk("aclr busy", busy, 0);
        chk("aclr done", done, 0);
        chk("aclr quotient", quotient, 0);
        chk("aclr remainder", remainder, 0);
        chk("aclr div_by_zero", div_by_zero, 0);
        chk("aclr state", 32'(dut.state), 32'(IDLE));
        chk("aclr step_cnt", 32'(dut.step_cnt), 0);
        chk("aclr internal_rem", 32'(dut.rem_r), 0);
        #1;
        aclr   = 1'b0;
        n_done = 0;
        n_busy = 0;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (done) n_done++;
            if (busy) n_busy++;
        end
        chk("post_aclr done_count", n_done, 0);
        chk("post_aclr busy_count", n_busy, 0);
        run_op("9/2", 8'd9, 8'd2);

        // Back-to-back stream: each new start is presented during the done cycle
        issued    = 0;
        got       = 0;
        cyc       = 0;
        last_done = 0;
        @(negedge clk);
        issue_op(issued);
        issued++;
        while (got < TOTAL && cyc < TOTAL * (N + 2) + 50) begin
            @(negedge clk);
            cyc++;
            start = 1'b0;
            if (done) begin
                if (eq_q.size() == 0) begin
                    chk("b2b spurious_done", 1, 0);
                end else begin
                    chk("b2b quotient", quotient, eq_q.pop_front());
                    chk("b2b remainder", remainder, er_q.pop_front());
                    chk("b2b div_by_zero", div_by_zero, ez_q.pop_front());
                    if (got > 0) begin
                        chk("b2b gap", cyc - last_done, gap_q[0]);
                    end
                    void'(gap_q.pop_front());
                end
                last_done = cyc;
                got++;
                if (issued < TOTAL) begin
                    issue_op(issued);
                    issued++;
                end
            end
        end
        chk("b2b result_count", got, TOTAL);
        n_done = 0;
        for (int i = 0; i < 2 * N; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("b2b trailing_done", n_done, 0);
        chk("b2b pending", eq_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/seq_div_n_bits.md
SEQ_DIV_N_BITS -- requirements
Module: seq_div_n_bits

Interface
REQ-001 Parameter N SHALL be: N, default 8, operand/result width in bits (N >= 2).
REQ-002 Port clk SHALL be: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port aclr SHALL be: aclr  input  1  reset, asynchronous, active-high.
REQ-004 Port start SHALL be: start  input  1  request a divide; sampled on rising clk edge.
REQ-005 Port dividend SHALL be: dividend  input  N  unsigned numerator; captured with start.
REQ-006 Port divisor SHALL be: divisor  input  N  unsigned denominator; captured with start.
REQ-007 Port busy SHALL be: busy  output  1  high while iterating (state CALC).
REQ-008 Port done SHALL be: done  output  1  one-cycle pulse marking new results valid.
REQ-009 Port quotient SHALL be: quotient  output  N  registered unsigned quotient.
REQ-010 Port remainder SHALL be: remainder  output  N  registered unsigned remainder.
REQ-011 Port div_by_zero SHALL be: div_by_zero  output  1  registered flag, set when the last captured divisor = 0.

Function
REQ-012 Algorithm SHALL be restoring division, one quotient bit per clock, MSB first.
- Each step: trial subtract divisor from {partial_remainder, next dividend bit}, using N+1-bit arithmetic.
- Non-negative trial result: keep it, quotient bit = 1.
- Negative trial result: restore the previous value, quotient bit = 0.
REQ-013 FSM states SHALL be exactly IDLE, CALC and DONE.
REQ-014 Transitions SHALL be:
- IDLE/DONE + start, divisor != 0 -> CALC.
- IDLE/DONE + start, divisor = 0 -> DONE.
- CALC with step counter exhausted -> DONE.
- DONE without start -> IDLE.
- IDLE without start -> IDLE.
REQ-015 start SHALL be accepted only when busy = 0 (IDLE or DONE); start during CALC SHALL be ignored, and operands SHALL NOT change.
REQ-016 Start accepted at edge E0 SHALL capture dividend and divisor, clear div_by_zero, and load the step counter with N.
REQ-017 The Nth CALC step, at edge E0+N, SHALL write quotient and remainder and assert done for exactly the following cycle; latency = N cycles.
REQ-018 Divisor = 0 SHALL produce, at edge E0+1:
- quotient = all ones;
- remainder = dividend;
- div_by_zero = 1;
- done pulse;
- no CALC cycles.
REQ-019 quotient, remainder and div_by_zero SHALL hold their values from the done pulse until the next done pulse or aclr.
REQ-020 quotient and remainder SHALL NOT be updated during CALC; intermediate values stay internal.
REQ-021 Results SHALL satisfy quotient*divisor + remainder = dividend, with remainder < divisor, for every divisor != 0.
REQ-022 Back-to-back operation: start asserted during the done cycle SHALL be accepted, giving a throughput of one result per N+1 cycles.
REQ-023 busy SHALL be a registered decode of state CALC; done SHALL be registered; no output SHALL be combinational from inputs.

Reset
REQ-024 aclr high SHALL immediately, without waiting for clk, force:
- state = IDLE;
- busy = 0, done = 0, div_by_zero = 0;
- quotient = 0, remainder = 0;
- step counter and internal remainder = 0.
REQ-025 aclr asserted mid-CALC SHALL abort the operation; no done pulse SHALL follow reset release.
REQ-026 After aclr deasserts, the first start SHALL be accepted on the first rising edge at which it is sampled high.

Structure
REQ-027 A shared package SHALL hold:
- the FSM state enumeration (IDLE, CALC, DONE);
- a function returning the counter width, ceil(log2(N+1)).
REQ-028 A single combinational sub-module div_step SHALL implement one trial subtract/restore step, with outputs next partial remainder and quotient bit; the top SHALL contain the FSM, counter and registers.

Verification
REQ-029 The bench SHALL cover, at N=8:
- 100/7 -> after 8 cycles done=1, quotient=14, remainder=2, div_by_zero=0, busy high for exactly 8 cycles.
- 5/0 -> done one cycle after start, quotient=255, remainder=5, div_by_zero=1, busy never high.
- 3/10 -> quotient=0, remainder=3; then 255/1 -> quotient=255, remainder=0.
- start pulsed with 200/3 at cycle 4 of a 100/7 operation -> ignored; results 14/2 only, one done pulse.
- aclr pulsed mid-CALC, between clock edges -> all outputs 0 immediately, state IDLE, no done after release; a new 9/2 then yields quotient=4, remainder=1.
- Back-to-back starts held during done, then 1000 random operand pairs -> every result matches the reference model, one done per accepted start.
